irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Machine-level interrupt controller in front of the exception unit.
- Latches edge-triggered external interrupt sources and applies a per-source enable mask.
- Selects the highest-priority pending interrupt and presents it to the exception unit with a valid/ack handshake.
- Tracks whether a trap handler is active until `mret`. Optionally includes a 64-bit machine timer (mtime/mtimecmp).

Parameters:
- NSRC, 8, number of external interrupt sources (1..16).
- EXT_CAUSE_BASE, 16, cause code of external source 0; source i uses EXT_CAUSE_BASE+i.

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous active-low reset
- irq_src  input  NSRC  external sources, synchronous to CLK, rising-edge sensitive
- global_ie  input  1  interrupt_en from CSR (mstatus.MIE)
- mask_wen  input  1  write enable for enable mask
- mask_wdata  input  NSRC  new enable mask
- irq_ack  input  1  exception unit has taken the presented interrupt
- mret  input  1  mret retired
- irq_valid  output  1  interrupt request to exception unit
- irq_cause  output  32 (word_t)  mcause value; bit 31 set
- irq_id  output  5  winning source id (NSRC = timer)
- in_handler  output  1  handler active
- pending  output  NSRC  pending bits (debug/CSR read)
- tmr_wen  input  1  mtimecmp write
- tmr_hi  input  1  0: write low word, 1: write high word
- tmr_wdata  input  32  mtimecmp write data
- mtime  output  64  current machine time

Behaviour:
- Reset values:
  - irq_valid=0, irq_cause=0, irq_id=0, in_handler=0, pending=0.
  - Mask=0, previous-sample register=0, mtime=0, mtimecmp=all ones.
  - State=IDLE.
- Edge detect: pending[i] sets on the cycle after irq_src[i] goes 0→1 (compared against the registered previous sample). Level-high sources do not re-set pending.
- Pending clear: pending[winner] clears on irq_ack in REQ. If a new edge arrives in the same cycle, set wins and the bit stays 1.
- Eligible set: `pending & mask` for external sources, plus the timer term (mtime >= mtimecmp, unsigned 64-bit) when the timer is compiled in.
- Priority: lowest external index wins; timer is lowest priority. Timer cause = 0x8000_0007.
- State machine:
  - IDLE: if global_ie and any eligible source, latch winner id/cause and go to REQ. irq_valid rises on the next cycle.
  - REQ: irq_valid=1; cause and id are held stable; mask changes do not withdraw the request.
    - irq_ack → HANDLER next cycle, irq_valid=0, in_handler=1.
    - global_ie=0 without ack → IDLE, irq_valid=0; pending is retained.
    - irq_ack takes precedence if it coincides with global_ie=0.
  - HANDLER: no new requests are issued. mret → IDLE, in_handler=0. A new request can be issued at the earliest 1 cycle after IDLE is re-entered.
- Ignored inputs: irq_ack outside REQ is ignored. mret outside HANDLER is ignored.
- Mask write: takes effect on the next cycle.
- Latency: source edge to irq_valid is 2 cycles minimum.
- Timer:
  - mtime increments every cycle and wraps 2^64-1 → 0.
  - The timer term is level-sensitive and is not cleared by ack; software clears it by rewriting mtimecmp.
  - A half-word write to mtimecmp affects the compare on the next cycle.
- Reset asserted mid-operation: all state returns to reset values at the clock edge, including dropping an in-flight irq_valid.

Optional Feature:
- IRQ_TIMER_EN defined: mtime/mtimecmp logic is present as described.
- IRQ_TIMER_EN undefined:
  - Timer registers are removed; the timer term is constant 0.
  - mtime output is tied to 0; tmr_wen/tmr_hi/tmr_wdata are ignored.
  - Ports remain, so the interface is unchanged.

Decomposition:
- common_types_pkg gets:
  - irq_state_t enum (IDLE, REQ, HANDLER).
  - Constants IRQ_CAUSE_MTI=32'h8000_0007 and IRQ_INT_BIT=31.
- One sub-module, irq_prio_enc: combinational fixed-priority encoder that takes the eligible vector and outputs found/id.
- The timer stays inline, guarded by the macro.

Test Plan:
- Single pulse: mask=0x01, global_ie=1, pulse irq_src[0] → irq_valid=1 two cycles later, irq_cause=0x8000_0010, irq_id=0. Ack → pending[0]=0, in_handler=1. mret → in_handler=0.
- Priority: edges on src 5 and src 2 in the same cycle, mask=0xFF → id 2 served first. After mret, id 5 is presented with cause 0x8000_0015.
- Masking and global enable:
  - Edge on src 3 with mask=0: pending[3]=1, no irq_valid.
  - Write mask=0x08 → irq_valid follows.
  - Drop global_ie in REQ → irq_valid=0 and pending[3] still 1.
- Ack/set collision: a new src 1 edge in the ack cycle for src 1 → pending[1] stays 1. It is re-presented after mret.
- Timer (IRQ_TIMER_EN): write mtimecmp=100 (hi=0, then lo=100) → irq_valid when mtime reaches 100, cause 0x8000_0007. After ack and mret, rewrite mtimecmp=all ones → no further request.
- Reset mid-REQ: assert nRST=0 for one cycle while irq_valid=1 → all outputs return to 0 and mtime=0.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
package common_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HANDLER = 2'd2
   } irq_state_t;

   localparam word_t IRQ_CAUSE_MTI = 32'h8000_0007;
   localparam int    IRQ_INT_BIT   = 31;

   // mcause for external source id: interrupt bit plus base-relative code
   function automatic word_t ext_cause(input int base, input logic [4:0] id);
      return (word_t'(base) + word_t'(id)) | (word_t'(1'b1) << IRQ_INT_BIT);
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of req wins.
module irq_prio_enc #(
   parameter int N = 9
) (
   input  logic [N-1:0] req,
   output logic         found,
   output logic [4:0]   id
);

   always_comb begin
      found = 1'b0;
      id    = 5'd0;
      for (int i = 0; i < N; i++) begin
         id    = (req[i] && !found) ? 5'(i) : id;
         found = found | req[i];
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Machine interrupt controller: edge latching, masking, priority select, valid/ack handshake.
// Optional 64-bit machine timer is compiled in when IRQ_TIMER_EN is defined.
module irq_controller
   import common_types_pkg::*;
#(
   parameter int NSRC           = 8,
   parameter int EXT_CAUSE_BASE = 16
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic [NSRC-1:0] irq_src,
   input  logic            global_ie,
   input  logic            mask_wen,
   input  logic [NSRC-1:0] mask_wdata,
   input  logic            irq_ack,
   input  logic            mret,
   output logic            irq_valid,
   output word_t           irq_cause,
   output logic [4:0]      irq_id,
   output logic            in_handler,
   output logic [NSRC-1:0] pending,
   input  logic            tmr_wen,
   input  logic            tmr_hi,
   input  logic [31:0]     tmr_wdata,
   output logic [63:0]     mtime
);

   irq_state_t      state_q, state_d;
   logic            valid_q, valid_d;
   word_t           cause_q, cause_d;
   logic [4:0]      id_q, id_d;
   logic            in_handler_q, in_handler_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] prev_q, prev_d;

   logic            timer_hit;
   logic [NSRC:0]   eligible;
   logic            win_found;
   logic [4:0]      win_id;
   word_t           win_cause;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] clr;
   logic            ack_take;

`ifdef IRQ_TIMER_EN
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;

   always_comb begin
      mtime_d    = mtime_q + 64'd1;
      mtimecmp_d = mtimecmp_q;
      if (tmr_wen) begin
         if (tmr_hi) begin
            mtimecmp_d[63:32] = tmr_wdata;
         end else begin
            mtimecmp_d[31:0] = tmr_wdata;
         end
      end else begin
         mtimecmp_d = mtimecmp_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= {64{1'b1}};
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
      end
   end

   assign timer_hit = (mtime_q >= mtimecmp_q);
   assign mtime     = mtime_q;
`else
   logic unused_tmr;
   assign unused_tmr = ^{tmr_wen, tmr_hi, tmr_wdata};
   assign timer_hit  = 1'b0;
   assign mtime      = 64'd0;
`endif

   // Timer sits above all external sources so it is the lowest priority.
   assign eligible = {timer_hit, pending_q & mask_q};

   irq_prio_enc #(.N(NSRC + 1)) u_prio (
      .req   (eligible),
      .found (win_found),
      .id    (win_id)
   );

   assign win_cause = (win_id == 5'(NSRC)) ? IRQ_CAUSE_MTI : ext_cause(EXT_CAUSE_BASE, win_id);

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      cause_d      = cause_q;
      id_d         = id_q;
      in_handler_d = in_handler_q;
      rise         = irq_src & ~prev_q;
      ack_take     = (state_q == REQ) && irq_ack;
      for (int i = 0; i < NSRC; i++) begin
         clr[i] = ack_take && (id_q == 5'(i));
      end
      // A fresh edge in the ack cycle re-arms the bit.
      pending_d = (pending_q & ~clr) | rise;
      prev_d    = irq_src;
      mask_d    = mask_wen ? mask_wdata : mask_q;

      case (state_q)
         IDLE: begin
            if (global_ie && win_found) begin
               state_d = REQ;
               valid_d = 1'b1;
               id_d    = win_id;
               cause_d = win_cause;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_d      = HANDLER;
               valid_d      = 1'b0;
               in_handler_d = 1'b1;
            end else if (!global_ie) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else begin
               state_d = REQ;
            end
         end
         HANDLER: begin
            if (mret) begin
               state_d      = IDLE;
               in_handler_d = 1'b0;
            end else begin
               state_d = HANDLER;
            end
         end
         default: begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            in_handler_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= IDLE;
         valid_q      <= 1'b0;
         cause_q      <= 32'd0;
         id_q         <= 5'd0;
         in_handler_q <= 1'b0;
         pending_q    <= {NSRC{1'b0}};
         mask_q       <= {NSRC{1'b0}};
         prev_q       <= {NSRC{1'b0}};
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         cause_q      <= cause_d;
         id_q         <= id_d;
         in_handler_q <= in_handler_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         prev_q       <= prev_d;
      end
   end

   assign irq_valid  = valid_q;
   assign irq_cause  = cause_q;
   assign irq_id     = id_q;
   assign in_handler = in_handler_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

   localparam int NSRC = 8;
`ifdef IRQ_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            nRST;
   logic [NSRC-1:0] irq_src;
   logic            global_ie;
   logic            mask_wen;
   logic [NSRC-1:0] mask_wdata;
   logic            irq_ack;
   logic            mret;
   logic            irq_valid;
   logic [31:0]     irq_cause;
   logic [4:0]      irq_id;
   logic            in_handler;
   logic [NSRC-1:0] pending;
   logic            tmr_wen;
   logic            tmr_hi;
   logic [31:0]     tmr_wdata;
   logic [63:0]     mtime;

   always #5 CLK = ~CLK;

   irq_controller #(.NSRC(NSRC), .EXT_CAUSE_BASE(16)) dut (
      .CLK(CLK), .nRST(nRST), .irq_src(irq_src), .global_ie(global_ie),
      .mask_wen(mask_wen), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .mret(mret),
      .irq_valid(irq_valid), .irq_cause(irq_cause), .irq_id(irq_id),
      .in_handler(in_handler), .pending(pending), .tmr_wen(tmr_wen),
      .tmr_hi(tmr_hi), .tmr_wdata(tmr_wdata), .mtime(mtime)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [NSRC-1:0] m_pend, m_prev, m_mask;
   bit              m_req, m_inh;
   int              m_id;
   logic [31:0]     m_cause;
   logic [63:0]     m_mtime, m_cmp;

   task automatic model_update();
      logic [NSRC-1:0] np;
      int win;
      bit tmr;
      if (!nRST) begin
         m_pend = '0; m_prev = '0; m_mask = '0;
         m_req = 1'b0; m_inh = 1'b0; m_id = 0; m_cause = 32'd0;
         m_mtime = 64'd0; m_cmp = {64{1'b1}};
         return;
      end
      tmr = TIMER_EN && (m_mtime >= m_cmp);
      win = -1;
      for (int i = 0; i < NSRC; i++)
         if (win < 0 && m_pend[i] && m_mask[i]) win = i;
      if (win < 0 && tmr) win = NSRC;
      np = m_pend;
      if (m_req) begin
         if (irq_ack) begin
            m_req = 1'b0; m_inh = 1'b1;
            if (m_id < NSRC) np[m_id] = 1'b0;
         end else if (!global_ie) begin
            m_req = 1'b0;
         end
      end else if (m_inh) begin
         if (mret) m_inh = 1'b0;
      end else if (global_ie && win >= 0) begin
         m_req = 1'b1;
         m_id = win;
         m_cause = (win == NSRC) ? 32'h8000_0007 : 32'h8000_0000 + 32'd16 + 32'(win);
      end
      for (int i = 0; i < NSRC; i++)
         if (irq_src[i] && !m_prev[i]) np[i] = 1'b1;
      m_pend = np;
      m_prev = irq_src;
      if (mask_wen) m_mask = mask_wdata;
      if (TIMER_EN) begin
         m_mtime = m_mtime + 64'd1;
         if (tmr_wen) begin
            if (tmr_hi) m_cmp[63:32] = tmr_wdata;
            else        m_cmp[31:0]  = tmr_wdata;
         end
      end
   endtask

   task automatic compare_all();
      check("valid",      64'(irq_valid),  64'(m_req));
      check("cause",      64'(irq_cause),  64'(m_cause));
      check("id",         64'(irq_id),     64'(m_id));
      check("in_handler", 64'(in_handler), 64'(m_inh));
      check("pending",    64'(pending),    64'(m_pend));
      check("mtime",      mtime,           m_mtime);
   endtask

   // One clock: inputs already driven; model advances with the DUT, outputs compared at negedge.
   task automatic step();
      @(posedge CLK);
      model_update();
      @(negedge CLK);
      compare_all();
   endtask

   task automatic write_mask(input logic [NSRC-1:0] m);
      mask_wen = 1'b1; mask_wdata = m; step(); mask_wen = 1'b0;
   endtask

   task automatic pulse(input logic [NSRC-1:0] s);
      irq_src = s; step(); irq_src = '0; step();
   endtask

   task automatic ack_then_mret();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      mret = 1'b1; step(); mret = 1'b0;
   endtask

   initial begin
      nRST = 1'b0; irq_src = '0; global_ie = 1'b0; mask_wen = 1'b0; mask_wdata = '0;
      irq_ack = 1'b0; mret = 1'b0; tmr_wen = 1'b0; tmr_hi = 1'b0; tmr_wdata = 32'd0;
      @(negedge CLK);
      step();
      check("rst_valid", 64'(irq_valid), 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      check("rst_mtime", mtime, 64'd0);
      nRST = 1'b1;

      // Single pulse on source 0
      write_mask(8'h01);
      global_ie = 1'b1;
      pulse(8'h01);
      check("pulse_valid", 64'(irq_valid), 64'd1);
      check("pulse_cause", 64'(irq_cause), 64'h8000_0010);
      check("pulse_id", 64'(irq_id), 64'd0);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      check("pulse_ack_pend", 64'(pending[0]), 64'd0);
      check("pulse_ack_inh", 64'(in_handler), 64'd1);
      mret = 1'b1; step(); mret = 1'b0;
      check("pulse_mret_inh", 64'(in_handler), 64'd0);

      // Priority: sources 2 and 5 together
      write_mask(8'hFF);
      pulse(8'h24);
      check("prio_first", 64'(irq_id), 64'd2);
      ack_then_mret();
      step();
      check("prio_second_id", 64'(irq_id), 64'd5);
      check("prio_second_cause", 64'(irq_cause), 64'h8000_0015);
      ack_then_mret();

      // Masking and global enable
      write_mask(8'h00);
      pulse(8'h08);
      check("mask_pend3", 64'(pending[3]), 64'd1);
      check("mask_novalid", 64'(irq_valid), 64'd0);
      write_mask(8'h08);
      step();
      check("mask_valid", 64'(irq_valid), 64'd1);
      global_ie = 1'b0; step();
      check("gie_drop_valid", 64'(irq_valid), 64'd0);
      check("gie_drop_pend", 64'(pending[3]), 64'd1);
      global_ie = 1'b1; step();
      ack_then_mret();

      // Ack/set collision on source 1
      write_mask(8'hFF);
      pulse(8'h02);
      check("coll_id", 64'(irq_id), 64'd1);
      irq_ack = 1'b1; irq_src = 8'h02; step(); irq_ack = 1'b0; irq_src = '0;
      check("coll_pend", 64'(pending[1]), 64'd1);
      mret = 1'b1; step(); mret = 1'b0;
      step();
      check("coll_repeat", 64'({irq_valid, irq_id}), 64'({1'b1, 5'd1}));
      ack_then_mret();

`ifdef IRQ_TIMER_EN
      nRST = 1'b0; step(); nRST = 1'b1;
      tmr_wen = 1'b1; tmr_hi = 1'b1; tmr_wdata = 32'd0; step();
      tmr_hi = 1'b0; tmr_wdata = 32'd100; step();
      tmr_wen = 1'b0;
      begin
         int n;
         n = 0;
         while (!irq_valid && n < 300) begin step(); n++; end
         check("tmr_timeout", 64'(irq_valid), 64'd1);
      end
      check("tmr_cause", 64'(irq_cause), 64'h8000_0007);
      check("tmr_mtime", mtime, 64'd101);
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      tmr_wen = 1'b1; tmr_hi = 1'b1; tmr_wdata = 32'hFFFF_FFFF; step();
      tmr_hi = 1'b0; step(); tmr_wen = 1'b0;
      mret = 1'b1; step(); mret = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("tmr_quiet", 64'(irq_valid), 64'd0);
`endif

      // Reset while a request is outstanding
      write_mask(8'h01);
      pulse(8'h01);
      check("rstreq_pre", 64'(irq_valid), 64'd1);
      nRST = 1'b0; step(); nRST = 1'b1;
      check("rstreq_valid", 64'(irq_valid), 64'd0);
      check("rstreq_cause", 64'(irq_cause), 64'd0);
      check("rstreq_mtime", mtime, 64'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NSRC; i++)
            if ($urandom_range(0, 5) == 0) irq_src[i] = ~irq_src[i];
         global_ie  = ($urandom_range(0, 9) != 0);
         irq_ack    = ($urandom_range(0, 2) == 0);
         mret       = ($urandom_range(0, 3) == 0);
         mask_wen   = ($urandom_range(0, 15) == 0);
         mask_wdata = NSRC'($urandom);
         tmr_wen    = ($urandom_range(0, 31) == 0);
         tmr_hi     = $urandom_range(0, 1) == 1;
         tmr_wdata  = $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 4000));
         nRST       = ($urandom_range(0, 399) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
